// File: rtl/program_counter_if.sv
// program_counter_if
//   Bundles the program-counter datapath signals shared between the
//   next-address/control logic (master) and the PC register (slave).
//   Clock and reset are not part of the bundle.
//
//   Parameter:
//     WIDTH        address width in bits
//   Signals:
//     PCWrite      load enable, 1 = capture PCNext at the next rising edge
//     PCNext       candidate next PC value
//     PCResult     registered current PC
//     TempPCResult combinational preview of the PC after the next edge
interface program_counter_if #(
  parameter int WIDTH = 5
);
  logic             PCWrite;
  logic [WIDTH-1:0] PCNext;
  logic [WIDTH-1:0] PCResult;
  logic [WIDTH-1:0] TempPCResult;

  // Control/next-address side: drives the enable and candidate address.
  modport master (
    output PCWrite,
    output PCNext,
    input  PCResult,
    input  TempPCResult
  );

  // PC register side.
  modport slave (
    input  PCWrite,
    input  PCNext,
    output PCResult,
    output TempPCResult
  );
endinterface

// File: rtl/program_counter.sv
// program_counter
//   Write-enabled program-counter register for the CPU datapath. PCResult
//   holds the current instruction address and loads PCNext on a rising edge
//   of Clk when PCWrite is 1. TempPCResult previews the value PCResult will
//   take at the next rising edge, so hazard/debug logic can use it without
//   waiting a cycle.
//
//   Optional feature (macro PC_AUTOINC_EN):
//     defined   - with PCWrite=0 the PC increments by 1 each edge, wrapping
//                 modulo 2^WIDTH; PCWrite=1 still loads PCNext first.
//     undefined - with PCWrite=0 the PC holds; no incrementer is built.
//
//   Parameters:
//     WIDTH        address width (must match the interface WIDTH)
//     RESET_VALUE  PC value while Reset is asserted
//   Ports:
//     Clk          system clock, rising edge active
//     Reset        asynchronous active-low reset (0 = reset asserted)
//     bus          program_counter_if slave: PCWrite, PCNext in;
//                  PCResult, TempPCResult out
module program_counter #(
  parameter int               WIDTH       = 5,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                   Clk,
  input  logic                   Reset,
  program_counter_if.slave       bus
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;

  // Next-state selection; this same value feeds the preview output, which
  // is what guarantees PCResult after an edge equals the preview before it.
  always_comb begin
    pc_d = pc_q;
    if (bus.PCWrite) begin
      pc_d = bus.PCNext;
    end else begin
`ifdef PC_AUTOINC_EN
      pc_d = pc_q + {{(WIDTH-1){1'b0}}, 1'b1};
`else
      pc_d = pc_q;
`endif
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc_q <= RESET_VALUE;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.PCResult = pc_q;

  // Reset is asynchronous, so the preview must also be forced while it is
  // low: a pending load is discarded and the PC sits at RESET_VALUE.
  assign bus.TempPCResult = Reset ? pc_d : RESET_VALUE;

endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter
//   Directed bench for program_counter. Each step pushes the expected
//   PCResult/TempPCResult pair into a scoreboard queue when the stimulus is
//   driven; the pair is popped and compared once the DUT has responded.
module tb_program_counter;
  localparam int W = 5;

`ifdef PC_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic Clk;
  logic Reset;

  program_counter_if #(.WIDTH(W)) bus ();

  program_counter #(
    .WIDTH       (W),
    .RESET_VALUE (5'd0)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    string          tag;
    logic [W-1:0]   pc;
    logic [W-1:0]   tmp;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] m_pc;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference next-PC from the behavioural description.
  function automatic logic [W-1:0] f_next(input logic we, input logic [W-1:0] nx,
                                          input logic [W-1:0] pc);
    if (we) return nx;
    if (AUTOINC) return pc + 5'd1;
    return pc;
  endfunction

  function automatic logic [W-1:0] exp_tmp();
    if (Reset !== 1'b1) return '0;
    return f_next(bus.PCWrite, bus.PCNext, m_pc);
  endfunction

  task automatic set_in(input logic rst, input logic we, input logic [W-1:0] nx);
    Reset       = rst;
    bus.PCWrite = we;
    bus.PCNext  = nx;
    if (!rst) m_pc = '0;
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag = tag;
    e.pc  = m_pc;
    e.tmp = exp_tmp();
    sb.push_back(e);
  endtask

  task automatic pop_compare();
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_empty got 0 entries want 1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      assert (bus.PCResult === e.pc) else begin
        errors++;
        $error("FAIL %s PCResult got %0d want %0d", e.tag, bus.PCResult, e.pc);
      end
      checks++;
      assert (bus.TempPCResult === e.tmp) else begin
        errors++;
        $error("FAIL %s TempPCResult got %0d want %0d", e.tag, bus.TempPCResult, e.tmp);
      end
    end
  endtask

  // Combinational check between edges.
  task automatic comb_step(input string tag);
    push_exp(tag);
    #1;
    pop_compare();
  endtask

  // One rising edge with the current inputs held; sample 1 time unit after.
  task automatic clk_step(input string tag);
    if (Reset === 1'b1) m_pc = f_next(bus.PCWrite, bus.PCNext, m_pc);
    else                m_pc = '0;
    push_exp(tag);
    @(posedge Clk);
    #1;
    pop_compare();
  endtask

  // PCWrite must never be unknown while out of reset.
  always @(posedge Clk) begin
    if (Reset === 1'b1 && $isunknown(bus.PCWrite)) begin
      errors++;
      $error("FAIL pcwrite_x got %b want 0 or 1", bus.PCWrite);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_pc = '0;
    set_in(1'b0, 1'b0, 5'd0);
    comb_step("reset_init");

    // Load 12 so the asynchronous reset has something to clear.
    set_in(1'b1, 1'b1, 5'd12);
    comb_step("pre_load12");
    clk_step("load12");
    set_in(1'b1, 1'b0, 5'd0);
    #2;
    set_in(1'b0, 1'b0, 5'd0);
    comb_step("async_reset");

    // Held reset ignores PCWrite/PCNext across an edge.
    set_in(1'b0, 1'b1, 5'd9);
    clk_step("reset_hold");

    // Load 4, then idle two edges.
    set_in(1'b1, 1'b1, 5'd4);
    comb_step("load4_preview");
    clk_step("load4");
    set_in(1'b1, 1'b0, 5'd4);
    comb_step("idle_preview");
    clk_step("idle1");
    clk_step("idle2");

    // Reload 12, then change PCNext with PCWrite low.
    set_in(1'b1, 1'b1, 5'd12);
    clk_step("reload12");
    set_in(1'b1, 1'b0, 5'd31);
    comb_step("next_ignored");

    // Reset beats a pending load across an edge.
    set_in(1'b1, 1'b1, 5'd21);
    comb_step("pend21_preview");
    set_in(1'b0, 1'b1, 5'd21);
    comb_step("pend21_discard");
    clk_step("reset_priority");
    set_in(1'b1, 1'b1, 5'd21);
    comb_step("release_preview");
    clk_step("release_load21");

    // All-ones and all-zeros, with mid-cycle preview samples.
    set_in(1'b1, 1'b1, 5'd31);
    clk_step("load31");
    comb_step("load31_mid_a");
    comb_step("load31_mid_b");
    set_in(1'b1, 1'b1, 5'd0);
    comb_step("load0_preview");
    clk_step("load0");
    comb_step("load0_mid");

    // Idle sequence from 30: wraps through 31, 0, 1 when auto-increment is
    // built in, otherwise holds at 30.
    set_in(1'b1, 1'b1, 5'd30);
    clk_step("load30");
    set_in(1'b1, 1'b0, 5'd30);
    comb_step("idle30_preview");
    clk_step("idle30_e1");
    clk_step("idle30_e2");
    clk_step("idle30_e3");

    // A load takes priority over the idle behaviour.
    set_in(1'b1, 1'b1, 5'd7);
    clk_step("load7_priority");

    // Several back-to-back loads with PCWrite held high.
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, 1'b1, W'($urandom_range(0, 31)));
      clk_step("burst_load");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
